// File: rtl/aes_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_ctrl_pkg
// Description : Shared types and constants for the AES job controller.
// Revision    : 1.0 - initial release
// ============================================================================
package aes_ctrl_pkg;

    localparam int AES_BLOCK_W          = 128;
    localparam int CORE_LATENCY_DEFAULT = 31;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_KEYLD = 3'd1,
        ST_START = 3'd2,
        ST_RUN   = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

    typedef struct packed {
        logic [AES_BLOCK_W-1:0] plain;
        logic [AES_BLOCK_W-1:0] key;
        logic                   id;
    } job_t;

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-way round-robin arbiter with a registered priority pointer.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2 (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] grant
);

    // 0 favours req[0], 1 favours req[1]
    logic r_ptr;

    always_comb begin
        grant = 2'b00;
        if (req[0] && req[1]) begin
            grant = r_ptr ? 2'b10 : 2'b01;
        end else if (req[0]) begin
            grant = 2'b01;
        end else if (req[1]) begin
            grant = 2'b10;
        end
    end

    // After serving one side, priority passes to the other
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr <= 1'b0;
        end else if (accept) begin
            r_ptr <= ~grant[1];
        end
    end

endmodule
`default_nettype wire

// File: rtl/aes_enc_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : aes_enc_arbiter
// Description : Shares one AES core between two requesters, one job in flight.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_enc_arbiter
    import aes_ctrl_pkg::*;
#(
    parameter int CORE_LATENCY = CORE_LATENCY_DEFAULT,
    parameter int BLOCK_W      = AES_BLOCK_W
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [BLOCK_W-1:0] req0_plain,
    input  logic [BLOCK_W-1:0] req0_key,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [BLOCK_W-1:0] req1_plain,
    input  logic [BLOCK_W-1:0] req1_key,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_id,
    output logic [BLOCK_W-1:0] rsp_cipher,
    output logic [BLOCK_W-1:0] core_plain_text,
    output logic [BLOCK_W-1:0] core_key_in,
    output logic               core_start,
    output logic               core_restart,
    input  logic [BLOCK_W-1:0] core_cipher_text,
    output logic               busy
);

    localparam int                c_cnt_w    = $clog2(CORE_LATENCY + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(CORE_LATENCY - 1);

    state_t               r_state;
    state_t               w_state_nxt;
    job_t                 r_job;
    logic [BLOCK_W-1:0]   r_key_cache;
    logic                 r_key_vld;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [BLOCK_W-1:0]   r_rsp_cipher;
    logic                 r_rsp_id;

    logic [1:0]           w_grant;
    logic                 w_accept;
    logic [BLOCK_W-1:0]   w_sel_key;
    logic                 w_key_hit;

    rr_arb2 u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req     ({req1_valid, req0_valid}),
        .accept  (w_accept),
        .grant   (w_grant)
    );

    assign w_accept  = (r_state == ST_IDLE) && (w_grant != 2'b00);
    assign w_sel_key = w_grant[1] ? req1_key : req0_key;
    assign w_key_hit = r_key_vld && (r_key_cache == w_sel_key);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        core_start   = 1'b0;
        core_restart = 1'b0;
        rsp_valid    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                req0_ready = w_grant[0];
                req1_ready = w_grant[1];
                if (w_accept) begin
                    w_state_nxt = w_key_hit ? ST_START : ST_KEYLD;
                end
            end
            ST_KEYLD: begin
                core_restart = 1'b1;
                w_state_nxt  = ST_START;
            end
            ST_START: begin
                core_start  = 1'b1;
                w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Job operands stay on the core inputs until the next acceptance
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_job        <= '0;
            r_key_cache  <= '0;
            r_key_vld    <= 1'b0;
            r_cnt        <= '0;
            r_rsp_cipher <= '0;
            r_rsp_id     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_job.plain <= w_grant[1] ? req1_plain : req0_plain;
                r_job.key   <= w_sel_key;
                r_job.id    <= w_grant[1];
            end
            if (r_state == ST_KEYLD) begin
                r_key_cache <= r_job.key;
                r_key_vld   <= 1'b1;
            end
            if (r_state == ST_START) begin
                r_cnt <= c_cnt_load;
            end else if ((r_state == ST_RUN) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if ((r_state == ST_RUN) && (r_cnt == '0)) begin
                r_rsp_cipher <= core_cipher_text;
                r_rsp_id     <= r_job.id;
            end
        end
    end

    assign core_plain_text = r_job.plain;
    assign core_key_in     = r_job.key;
    assign rsp_cipher      = r_rsp_cipher;
    assign rsp_id          = r_rsp_id;
    assign busy            = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_aes_enc_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_enc_arbiter
// Description : Scoreboard bench for aes_enc_arbiter with a behavioural core.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_enc_arbiter;

    localparam int L = 31;
    localparam int W = 128;

    localparam logic [W-1:0] K0  = 128'h00010203_04050607_08090a0b_0c0d0e0f;
    localparam logic [W-1:0] PA  = 128'h00112233_44556677_8899aabb_ccddeeff;
    localparam logic [W-1:0] CA  = 128'h69c4e0d8_6a7b0430_d8cdb780_70b4c55a;
    localparam logic [W-1:0] K2  = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
    localparam logic [W-1:0] PC  = 128'h3243f6a8_885a308d_313198a2_e0370734;
    localparam logic [W-1:0] CC  = 128'h3925841d_02dc09fb_dc118597_196a0b32;
    localparam logic [W-1:0] PZ  = 128'h0;
    localparam logic [W-1:0] PX0 = 128'ha0000000_00000000_00000000_00000000;
    localparam logic [W-1:0] PX1 = 128'hb1000000_00000000_00000000_00000000;
    localparam logic [W-1:0] PX2 = 128'hc2000000_00000000_00000000_00000000;
    localparam logic [W-1:0] PX3 = 128'hd3000000_00000000_00000000_00000000;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         req0_valid = 1'b0, req1_valid = 1'b0;
    logic         req0_ready, req1_ready;
    logic [W-1:0] req0_plain = '0, req0_key = '0, req1_plain = '0, req1_key = '0;
    logic         rsp_valid, rsp_id;
    logic         rsp_ready = 1'b1;
    logic [W-1:0] rsp_cipher, core_plain_text, core_key_in, core_cipher_text;
    logic         core_start, core_restart, busy;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic         id;
        logic [W-1:0] cipher;
        int           restarts;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    aes_enc_arbiter #(.CORE_LATENCY(L), .BLOCK_W(W)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .req0_valid       (req0_valid),
        .req0_ready       (req0_ready),
        .req0_plain       (req0_plain),
        .req0_key         (req0_key),
        .req1_valid       (req1_valid),
        .req1_ready       (req1_ready),
        .req1_plain       (req1_plain),
        .req1_key         (req1_key),
        .rsp_valid        (rsp_valid),
        .rsp_ready        (rsp_ready),
        .rsp_id           (rsp_id),
        .rsp_cipher       (rsp_cipher),
        .core_plain_text  (core_plain_text),
        .core_key_in      (core_key_in),
        .core_start       (core_start),
        .core_restart     (core_restart),
        .core_cipher_text (core_cipher_text),
        .busy             (busy)
    );

    // Core stand-in: known vectors from a table, XOR otherwise; result valid only in cycle L after start
    logic [W-1:0] m_key = '0, m_plain = '0;
    int           m_cnt = 0;

    function automatic logic [W-1:0] core_fn(input logic [W-1:0] p, input logic [W-1:0] k);
        if (k == K0 && p == PA) return CA;
        if (k == K2 && p == PC) return CC;
        return p ^ k;
    endfunction

    always @(posedge clk) begin
        if (core_restart) m_key <= core_key_in;
        if (core_start) begin
            m_plain <= core_plain_text;
            m_cnt   <= 1;
        end else if (m_cnt != 0 && m_cnt < 1000) begin
            m_cnt <= m_cnt + 1;
        end
    end

    assign core_cipher_text = (m_cnt == L) ? core_fn(m_plain, m_key) : {4{32'hDEADBEEF}};

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic id, input logic [W-1:0] c, input int r);
        exp_t e;
        e.id = id; e.cipher = c; e.restarts = r;
        sb.push_back(e);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ctl"}, W'({busy, rsp_valid, rsp_id, core_start, core_restart, req0_ready, req1_ready}), '0);
        check({tag, "_rsp_cipher"}, rsp_cipher, '0);
        check({tag, "_core_plain"}, core_plain_text, '0);
        check({tag, "_core_key"}, core_key_in, '0);
    endtask

    task automatic drive(input bit id, input logic [W-1:0] p, input logic [W-1:0] k);
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        @(negedge clk);
        if (id) begin req1_plain = p; req1_key = k; req1_valid = 1'b1; end
        else    begin req0_plain = p; req0_key = k; req0_valid = 1'b1; end
        #1;
        while (!done) begin
            if ((id ? req1_ready : req0_ready) === 1'b1) begin
                @(posedge clk);
                #1;
                done = 1'b1;
            end else if (n >= 500) begin
                n_cmp++; n_err++;
                $display("FAIL req%0d_accept_timeout: got no ready required ready within 500 cycles", id);
                done = 1'b1;
            end else begin
                @(negedge clk);
                #1;
                n++;
            end
        end
        if (id) req1_valid = 1'b0;
        else    req0_valid = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while ((sb.size() != 0 || busy !== 1'b0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            n_cmp++; n_err++;
            $display("FAIL %s_drain: got %0d pending required 0", tag, sb.size());
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Monitor: pops the scoreboard on every response handshake
    initial begin : monitor
        int n_rst, n_st, lat;
        bit act;
        exp_t e;
        n_rst = 0; n_st = 0; lat = 0; act = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                n_rst = 0; n_st = 0; act = 1'b0;
            end else begin
                if (act) begin
                    lat++;
                    if (rsp_valid) begin
                        check("start_to_rsp_valid", W'(lat), W'(L + 1));
                        act = 1'b0;
                    end
                end
                if (core_restart) n_rst++;
                if (core_start) begin
                    n_st++;
                    act = 1'b1;
                    lat = 0;
                end
                if (rsp_valid && rsp_ready) begin
                    if (sb.size() == 0) begin
                        n_cmp++; n_err++;
                        $display("FAIL unexpected_rsp: got id %0d cipher %h required none", rsp_id, rsp_cipher);
                    end else begin
                        e = sb.pop_front();
                        check("rsp_id", W'(rsp_id), W'(e.id));
                        check("rsp_cipher", rsp_cipher, e.cipher);
                        check("restart_pulses", W'(n_rst), W'(e.restarts));
                        check("start_pulses", W'(n_st), W'(1));
                    end
                    n_rst = 0;
                    n_st = 0;
                end
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL global_timeout: got still running required finish");
        $fatal(1, "timeout");
    end

    initial begin : main
        int n;
        // Reset state while reset is asserted
        #3;
        check_outputs_zero("reset");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // Single job, then key hit, then key change
        push(1'b0, CA, 1);
        drive(1'b0, PA, K0);
        wait_drain("single");
        push(1'b0, K0, 0);
        drive(1'b0, PZ, K0);
        wait_drain("key_hit");
        push(1'b1, CC, 1);
        drive(1'b1, PC, K2);
        wait_drain("key_change");

        // Backpressure with a pending req1 job
        @(posedge clk); #1 rsp_ready = 1'b0;
        push(1'b0, 128'h8b7e1516_28aed2a6_abf71588_09cf4f3c, 0);
        push(1'b1, 128'h9a7e1516_28aed2a6_abf71588_09cf4f3c, 0);
        drive(1'b0, PX0, K2);
        fork
            drive(1'b1, PX1, K2);
            begin
                n = 0;
                while (rsp_valid !== 1'b1 && n < 200) begin
                    @(negedge clk);
                    n++;
                end
                check("bp_rsp_valid_seen", W'(rsp_valid), W'(1));
                repeat (5) begin
                    @(negedge clk);
                    check("bp_hold_valid", W'(rsp_valid), W'(1));
                    check("bp_hold_cipher", rsp_cipher, 128'h8b7e1516_28aed2a6_abf71588_09cf4f3c);
                    check("bp_hold_id", W'(rsp_id), W'(0));
                    check("bp_no_ready", W'({req0_ready, req1_ready}), W'(0));
                end
                @(posedge clk); #1 rsp_ready = 1'b1;
                @(negedge clk);
                @(negedge clk);
                check("bp_grant_after_idle", W'({busy, req1_ready}), W'(2'b01));
            end
        join
        wait_drain("backpressure");

        // Contention after reset: grants alternate starting with req0
        do_reset();
        push(1'b0, 128'ha0010203_04050607_08090a0b_0c0d0e0f, 1);
        push(1'b1, 128'hb1010203_04050607_08090a0b_0c0d0e0f, 0);
        push(1'b0, 128'hc2010203_04050607_08090a0b_0c0d0e0f, 0);
        push(1'b1, 128'hd3010203_04050607_08090a0b_0c0d0e0f, 0);
        fork
            begin drive(1'b0, PX0, K0); drive(1'b0, PX2, K0); end
            begin drive(1'b1, PX1, K0); drive(1'b1, PX3, K0); end
        join
        wait_drain("contention");

        // Reset while the counter reads 10, then a job with the same key
        drive(1'b0, PX0, K0);
        n = 0;
        while (core_start !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("abort_start_seen", W'(core_start), W'(1));
        repeat (L - 10) @(negedge clk);
        check("abort_busy_before", W'(busy), W'(1));
        #2 reset_n = 1'b0;
        #1 check_outputs_zero("abort");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        push(1'b0, K0, 1);
        drive(1'b0, PZ, K0);
        wait_drain("after_abort");

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/aes_enc_arbiter.md
Name: aes_enc_arbiter

Overview:
Job controller that shares one encryption core (plaintext/key in, start/restart control, cipher_text out) between two requesters. It arbitrates round-robin, holds the job operands, and pulses the core's key-restart only when the key changes. It pulses start, times the core's fixed latency, captures the ciphertext and returns it on a valid/ready response port tagged with the requester id. It sits between the system-side request sources and the encryption top level, with one job in flight at a time.

Parameters:
CORE_LATENCY, 31, cycles from the core_start pulse to the cycle in which core_cipher_text holds the final ciphertext; legal range >= 1
BLOCK_W, 128, plaintext/key/ciphertext width

Ports:
clk  in  1  single clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
req0_valid  in  1  requester 0 has a job
req0_ready  out  1  requester 0 job accepted this cycle
req0_plain  in  BLOCK_W  requester 0 plaintext
req0_key  in  BLOCK_W  requester 0 key
req1_valid  in  1  requester 1 has a job
req1_ready  out  1  requester 1 job accepted this cycle
req1_plain  in  BLOCK_W  requester 1 plaintext
req1_key  in  BLOCK_W  requester 1 key
rsp_valid  out  1  ciphertext available
rsp_ready  in  1  consumer accepts response
rsp_id  out  1  requester that owns the response
rsp_cipher  out  BLOCK_W  ciphertext
core_plain_text  out  BLOCK_W  to core plaintext input
core_key_in  out  BLOCK_W  to core key input
core_start  out  1  one-cycle start pulse to core
core_restart  out  1  one-cycle key-expansion restart pulse
core_cipher_text  in  BLOCK_W  from core
busy  out  1  job in progress (state != IDLE)

Behaviour:
- Reset (async assert, sync release): every output and register is 0. State is IDLE, rr pointer favours req0, key cache is invalid.
- FSM states: IDLE, KEYLD, START, RUN, RESP.
- IDLE:
  - reqN_ready = 1 combinationally only for the arbiter-granted requester with reqN_valid = 1. At most one ready is high.
  - On the handshake, capture plain, key and id into job registers, and move the rr pointer to the other requester.
  - Next state is START if the key cache is valid and the cached key equals the captured key, else KEYLD.
- KEYLD (1 cycle): core_restart = 1; load the key cache with the job key and set it valid. Next state is START.
- START (1 cycle): core_start = 1; load the latency counter with CORE_LATENCY-1. Next state is RUN.
- RUN:
  - Decrement the counter each cycle.
  - In the cycle the counter reads 0, register core_cipher_text into rsp_cipher and the job id into rsp_id. Next state is RESP.
  - core_start to capture is CORE_LATENCY cycles.
- RESP:
  - rsp_valid = 1; rsp_cipher and rsp_id are held stable until rsp_ready.
  - On the handshake, go to IDLE; rsp_valid falls the next cycle.
  - No request is accepted while in RESP; there is no overlap.
- core_plain_text and core_key_in are driven from the job registers from the cycle after acceptance until the next acceptance. They are held (not zeroed) afterwards.
- Arbitration: both requests valid → pointer side wins. A single valid request always wins. This gives a max wait of one job per requester, so no starvation.
- reqN_valid dropping before ready has no effect; no state change.
- Reset mid-job: abort immediately. The job is lost with no response. The key cache is invalidated, so the next job always passes through KEYLD.
- Counter width is $clog2(CORE_LATENCY+1). CORE_LATENCY = 1 means RUN lasts exactly 1 cycle.
- rsp_ready high outside RESP is ignored.

Decomposition:
- Package aes_ctrl_pkg holds:
  - the state enum type;
  - the AES_BLOCK_W = 128 constant;
  - the CORE_LATENCY_DEFAULT = 31 constant;
  - the job struct {plain, key, id}.
- One sub-module, rr_arb2: a 2-way round-robin arbiter with a registered pointer. Inputs are req[1:0] and an accept strobe; output is a one-hot grant[1:0].
- FSM, counter and key cache stay in aes_enc_arbiter.

Test Plan:
- Single job from req0 after reset:
  - Stimulus: key 000102030405060708090a0b0c0d0e0f, plain 00112233445566778899aabbccddeeff, real core attached.
  - Response: core_restart pulses once, then core_start on the next cycle. rsp_valid rises CORE_LATENCY+1 cycles after core_start with rsp_cipher 69c4e0d86a7b0430d8cdb78070b4c55a and rsp_id 0.
- Key hit: a second req0 job with the same key and plain 00000000000000000000000000000000 → no core_restart pulse (KEYLD skipped), one core_start, correct cipher, rsp_id 0.
- Contention: req0_valid and req1_valid held high with the same key after reset → grant order 0,1,0,1 over four jobs, with rsp_id sequence matching. req1 never waits more than one job.
- Key change: req1 job with key 2b7e151628aed2a6abf7158809cf4f3c, plain 3243f6a8885a308d313198a2e0370734 after a cached key → core_restart pulses, rsp_cipher 3925841d02dc09fbdc118597196a0b32.
- Backpressure: rsp_ready held low 5 cycles in RESP → rsp_valid, rsp_cipher and rsp_id stable. Both reqN_ready stay 0 with requests pending. The next grant occurs the cycle after the IDLE return.
- Reset mid-RUN: assert reset_n = 0 at counter = 10 → all outputs 0 asynchronously. After release, the next job (same key as before) passes through KEYLD (core_restart = 1).
